// File: rtl/fpcvt_pkg.sv
// Shared widths and result type for the 13-bit integer to 9-bit float converter.
package fpcvt_pkg;

    localparam int IN_W    = 13;
    localparam int EXP_W   = 3;
    localparam int SIG_W   = 5;
    localparam int EXP_MAX = 7;
    localparam int SIG_MAX = 31;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] f;
    } fp9_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero count of a 12-bit magnitude (12 when the input is zero).
module fpcvt_lzc (
    input  logic [11:0] m,
    output logic [3:0]  lz
);

    // Scanning upward lets the highest set bit win the priority.
    always_comb begin
        lz = 4'd12;
        for (int unsigned i = 0; i < 12; i++) begin
            if (m[i]) lz = 4'(11 - i);
        end
    end

endmodule

// File: rtl/fpcvt_13to9.sv
// Two-stage pipelined converter: 13-bit two's-complement integer to {S, E[2:0], F[4:0]},
// magnitude F * 2^E, round-half-up on magnitude, saturating at 31 * 128.
module fpcvt_13to9
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  D,
    output logic             out_valid,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [SIG_W-1:0] F
);

    logic [IN_W-1:0] mag;
    logic [3:0]      lz_c;

    logic            s1_valid;
    logic            s1_s;
    logic            s1_sat;
    logic [11:0]     s1_m;
    logic [3:0]      s1_lz;

    fp9_t            res;
    logic [2:0]      e0;
    logic [5:0]      sh;
    logic [5:0]      sum;

    // Only -4096 reaches bit 12 of the magnitude; it is handled as saturation.
    assign mag = D[IN_W-1] ? IN_W'(13'd0 - D) : D;

    fpcvt_lzc u_lzc (
        .m  (mag[11:0]),
        .lz (lz_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= 1'b0;
            s1_sat   <= 1'b0;
            s1_m     <= '0;
            s1_lz    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_s   <= D[IN_W-1];
                s1_sat <= mag[12];
                s1_m   <= mag[11:0];
                s1_lz  <= lz_c;
            end
        end
    end

    // sh[5:1] is the truncated significand, sh[0] the round bit just below it.
    always_comb begin
        res   = '0;
        res.s = s1_s;
        e0    = '0;
        sh    = '0;
        sum   = '0;
        if (s1_sat) begin
            res.e = EXP_W'(EXP_MAX);
            res.f = SIG_W'(SIG_MAX);
        end else if (s1_lz >= 4'd7) begin
            res.f = s1_m[4:0];
        end else begin
            e0  = 3'(4'd7 - s1_lz);
            sh  = 6'(s1_m >> (e0 - 3'd1));
            sum = {1'b0, sh[5:1]} + {5'b0, sh[0]};
            if (sum[5]) begin
                if (e0 == EXP_W'(EXP_MAX)) begin
                    res.e = EXP_W'(EXP_MAX);
                    res.f = SIG_W'(SIG_MAX);
                end else begin
                    res.e = e0 + 3'd1;
                    res.f = 5'd16;
                end
            end else begin
                res.e = e0;
                res.f = sum[4:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= 1'b0;
            E         <= '0;
            F         <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                S <= res.s;
                E <= res.e;
                F <= res.f;
            end
        end
    end

endmodule

// File: tb/tb_fpcvt_13to9.sv
// Directed and exhaustive-stream checks for fpcvt_13to9.
module tb_fpcvt_13to9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] D = '0;
    logic        out_valid;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;

    int          n_vec = 0;
    int          n_miss = 0;
    bit          stream_on = 1'b0;
    logic [8:0]  exp_q[$];

    fpcvt_13to9 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .D         (D),
        .out_valid (out_valid),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: smallest exponent whose window holds the magnitude, then round half up.
    function automatic logic [8:0] ref_cvt(input logic [12:0] d);
        int   mag;
        int   e;
        int   q;
        logic s;
        s   = d[12];
        mag = s ? 8192 - int'(d) : int'(d);
        if (mag < 32) return {s, 3'd0, 5'(mag)};
        e = 0;
        while ((mag >> e) >= 32) e++;
        q = (mag + (1 << (e - 1))) >> e;
        if (q == 32) begin
            q = 16;
            e++;
        end
        if (e > 7) return {s, 3'd7, 5'd31};
        return {s, 3'(e), 5'(q)};
    endfunction

    task automatic run_vec(input string tag, input logic [12:0] d, input logic [8:0] exp);
        @(posedge clk); #1;
        D = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_lat"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_eq(tag, 32'({S, E, F}), 32'(exp));
        @(posedge clk); #1;
        check_eq({tag, "_hold"}, 32'({out_valid, S, E, F}), 32'({1'b0, exp}));
    endtask

    always @(negedge clk) begin
        if (stream_on && out_valid) begin
            if (exp_q.size() == 0) check_eq("stream_extra", 32'd1, 32'd0);
            else                   check_eq("stream", 32'({S, E, F}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #3;
        check_eq("rst_out", 32'({out_valid, S, E, F}), 32'd0);
        #10 rst_n = 1'b1;

        run_vec("d58",      13'h003A, 9'b0_001_11101);
        run_vec("d3969",    13'h0F81, 9'b0_111_11111);
        run_vec("dm4096",   13'h1000, 9'b1_111_11111);
        run_vec("d253",     13'h00FD, 9'b0_100_10000);
        run_vec("d4064",    13'h0FE0, 9'b0_111_11111);
        run_vec("dm898",    13'h1C7E, 9'b1_101_11100);
        run_vec("dm4",      13'h1FFC, 9'b1_000_00100);
        run_vec("d2",       13'h0002, 9'b0_000_00010);
        run_vec("d0",       13'h0000, 9'b0_000_00000);
        run_vec("d31",      13'h001F, 9'b0_000_11111);
        run_vec("d32",      13'h0020, 9'b0_001_10000);
        run_vec("d63",      13'h003F, 9'b0_010_10000);
        run_vec("d4095",    13'h0FFF, 9'b0_111_11111);

        stream_on = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            if (i == 3000) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            D = 13'(i);
            in_valid = 1'b1;
            exp_q.push_back(ref_cvt(13'(i)));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("stream_drain", 32'(exp_q.size()), 32'd0);
        stream_on = 1'b0;

        @(posedge clk); #1;
        D = 13'h003A;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_vld", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst", 32'({out_valid, S, E, F}), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("post_rst", 32'({out_valid, S, E, F}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
